// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bundle: run/redirect control, combinational imem read port, and the
// instruction-queue head handshake toward decode.
interface imem_fetch_ctrl_if;
  logic        run;
  logic [15:0] imem_pc;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        ifq_valid;
  logic [15:0] ifq_instr;
  logic [15:0] ifq_pc;
  logic        ifq_ready;
  logic [15:0] fetch_cnt;

  modport master (
    input  run, imem_instr, redirect_valid, redirect_pc, ifq_ready,
    output imem_pc, ifq_valid, ifq_instr, ifq_pc, fetch_cnt
  );

  modport slave (
    output run, imem_instr, redirect_valid, redirect_pc, ifq_ready,
    input  imem_pc, ifq_valid, ifq_instr, ifq_pc, fetch_cnt
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch into a 2-entry {pc,instr} queue; first push one edge after run enters FETCH.
// Fetch stalls while the queue is full with no pop; redirect flushes it.
// Optional IFETCH_PERF_CNT_EN adds a saturating delivered-instruction counter.
module imem_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_WRAP  = 16'h0020
) (
  input logic             clk,
  input logic             rst_n,
  imem_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, STALL} state_t;

  state_t      state, state_nxt;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic [1:0]  count, count_nxt;
  logic [15:0] e0_pc, e0_instr, e1_pc, e1_instr;
  logic        pop, push;

  always_comb begin
    pop       = (count != 2'd0) && bus.ifq_ready;
    push      = (state == FETCH) && bus.run && !bus.redirect_valid
                && ((count != 2'd2) || pop);
    pc_inc    = pc + 16'd2;
    count_nxt = count;
    if (bus.redirect_valid) begin
      count_nxt = 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + 2'd1;
        2'b01:   count_nxt = count - 2'd1;
        default: count_nxt = count;
      endcase
    end

    state_nxt = state;
    if (!bus.run) begin
      state_nxt = IDLE;
    end else if (bus.redirect_valid) begin
      // Redirect empties the queue, so a stalled fetch can resume right away.
      if (state == STALL) state_nxt = FETCH;
    end else begin
      case (state)
        IDLE:    state_nxt = FETCH;
        FETCH:   if (count_nxt == 2'd2) state_nxt = STALL;
        STALL:   if (pop) state_nxt = FETCH;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= 2'd0;
      pc       <= RESET_PC;
      e0_pc    <= 16'h0000;
      e0_instr <= 16'h0000;
      e1_pc    <= 16'h0000;
      e1_instr <= 16'h0000;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      if (bus.redirect_valid) begin
        pc <= {bus.redirect_pc[15:1], 1'b0};
      end else if (push) begin
        pc <= (pc_inc == PC_WRAP) ? 16'h0000 : pc_inc;
      end

      if (!bus.redirect_valid) begin
        if (pop) begin
          if (count == 2'd2) begin
            e0_pc    <= e1_pc;
            e0_instr <= e1_instr;
          end
          // With a pop, the new word lands behind whatever survives at the head.
          if (push) begin
            if (count == 2'd2) begin
              e1_pc    <= pc;
              e1_instr <= bus.imem_instr;
            end else begin
              e0_pc    <= pc;
              e0_instr <= bus.imem_instr;
            end
          end
        end else if (push) begin
          if (count == 2'd0) begin
            e0_pc    <= pc;
            e0_instr <= bus.imem_instr;
          end else begin
            e1_pc    <= pc;
            e1_instr <= bus.imem_instr;
          end
        end
      end
    end
  end

  assign bus.imem_pc   = pc;
  assign bus.ifq_valid = (count != 2'd0);
  assign bus.ifq_instr = e0_instr;
  assign bus.ifq_pc    = e0_pc;

`ifdef IFETCH_PERF_CNT_EN
  logic [15:0] perf_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cnt <= 16'h0000;
    end else if (pop && (perf_cnt != 16'hFFFF)) begin
      perf_cnt <= perf_cnt + 16'd1;
    end
  end

  assign bus.fetch_cnt = perf_cnt;
`else
  assign bus.fetch_cnt = 16'h0000;
`endif

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 16'h0000, meaning the fetch PC loaded at reset.
REQ-002 The block SHALL have parameter PC_WRAP, default 16'h0020, meaning the first PC past the last instruction word (16 words x 2 bytes).
REQ-003 The block SHALL have port clk, input, 1, meaning the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, meaning the reset, synchronous and active-low.
REQ-005 The block SHALL have port run, input, 1, meaning fetch enable.
REQ-006 The block SHALL have port imem_pc, output, 16, meaning the fetch address driven to instruction memory (combinational read, word index pc[4:1]).
REQ-007 The block SHALL have port imem_instr, input, 16, meaning the instruction word returned for imem_pc in the same cycle.
REQ-008 The block SHALL have port redirect_valid, input, 1, meaning a branch/jump redirect request.
REQ-009 The block SHALL have port redirect_pc, input, 16, meaning the redirect target.
REQ-010 The block SHALL have port ifq_valid, output, 1, meaning the queue head holds a valid instruction.
REQ-011 The block SHALL have port ifq_instr, output, 16, meaning the queue head instruction.
REQ-012 The block SHALL have port ifq_pc, output, 16, meaning the PC of the queue head instruction.
REQ-013 The block SHALL have port ifq_ready, input, 1, meaning the decode stage accepts the head this cycle.
REQ-014 The block SHALL have port fetch_cnt, output, 16, meaning the count of delivered instructions.

Function
REQ-015 The block SHALL hold a 2-entry FIFO of {pc, instr}; ifq_* SHALL be driven from the head entry registers; imem_pc SHALL equal the fetch PC register.
REQ-016 The FSM SHALL have states IDLE, FETCH and STALL.
REQ-017 Transitions: IDLE->FETCH when run=1; FETCH->STALL when the FIFO becomes full; STALL->FETCH on a pop; any state->IDLE when run=0.
REQ-018 Pop SHALL occur on a rising edge where ifq_valid=1 and ifq_ready=1.
REQ-019 Push SHALL occur only in FETCH, when count<2 or a pop occurs in the same edge, writing {imem_pc, imem_instr}.
REQ-020 On push, the PC SHALL advance by 2; if PC+2 equals PC_WRAP, it SHALL wrap to 16'h0000.
REQ-021 Simultaneous push and pop at count=2 SHALL keep count=2 with correct ordering; at count=1 SHALL keep count=1.
REQ-022 Latency: run sampled high at edge N gives FETCH after edge N; first push at edge N+1; ifq_valid=1 after edge N+1.
REQ-023 redirect_valid=1 SHALL have top priority: FIFO flushed (count=0), no push that edge, PC <= {redirect_pc[15:1],1'b0}; ifq_valid=0 after that edge.
REQ-024 A redirect SHALL be accepted in any state including IDLE; the FSM state is unchanged except STALL->FETCH.
REQ-025 A pop coincident with a redirect SHALL count as delivered.
REQ-026 With run=0, no push SHALL occur; queued entries SHALL remain poppable.

Reset
REQ-027 While rst_n=0 at an edge: PC=RESET_PC, FIFO count=0, state=IDLE, ifq_valid=0, ifq_instr=0, ifq_pc=0, fetch_cnt=0.
REQ-028 Reset mid-operation SHALL discard queued entries and override any simultaneous redirect, push or pop.

Configuration
REQ-029 Macro IFETCH_PERF_CNT_EN defined: fetch_cnt SHALL increment by 1 on each pop, saturating at 16'hFFFF.
REQ-030 Macro IFETCH_PERF_CNT_EN undefined: fetch_cnt SHALL be constant 16'h0000 and no counter register SHALL exist.

Verification
REQ-031 Test: reset, run=1, ifq_ready=1 -> ifq_pc sequence 0x0000,0x0002,... one per cycle, first valid 2 edges after run sampled.
REQ-032 Test: ifq_ready=0 for 5 cycles -> count stops at 2, state STALL, imem_pc=0x0004; ifq_ready=1 -> entries 0x0000,0x0002 popped in order, then 0x0004.
REQ-033 Test: PC reaches 0x001E, push -> next imem_pc=0x0000; ifq_pc sequence 0x001C,0x001E,0x0000.
REQ-034 Test: redirect_valid=1, redirect_pc=0x0011 while FIFO full -> ifq_valid=0 next cycle, imem_pc=0x0010, next delivered ifq_pc=0x0010.
REQ-035 Test: rst_n=0 for one edge mid-stream with redirect_valid=1 -> imem_pc=RESET_PC, ifq_valid=0, fetch_cnt=0.
REQ-036 Test (IFETCH_PERF_CNT_EN defined): 10 pops, one coincident with redirect -> fetch_cnt=10; macro undefined -> fetch_cnt=0.
